// File: rtl/geig_multi_counter.sv
// geig_multi_counter
// Multi-channel Geiger event counter. Each channel's GSTREAM input is
// synchronised, debounced and edge-detected; accepted rising edges are counted
// over a window of WINDOW_TICKS TICK_10HZ strobes. At each window close the
// counts are snapshotted and one tagged word per channel is emitted over a
// valid/ready handshake.
//
// Ports:
//   CLK_48MHZ     in   system clock
//   RESET         in   synchronous, active-high reset
//   TICK_10HZ     in   one-cycle 10 Hz strobe
//   TIMESTAMP     in   current mission time, latched at window close
//   GSTREAM       in   asynchronous Geiger pulse inputs, one bit per channel
//   G_DATA_STACK  out  {ID_GEIG, timestamp, SAT, CH[6:0], COUNT}, 0 when idle
//   G_VALID       out  G_DATA_STACK holds a word
//   G_READY       in   downstream accepts the word
//   G_OVERRUN     out  sticky: a window closed while an emission was in progress
module geig_multi_counter #(
   parameter int          NUM_CH       = 2,
   parameter int          CNT_W        = 8,
   parameter int          TS_W         = 24,
   parameter int          DEBOUNCE_CYC = 48,
   parameter int          WINDOW_TICKS = 600,
   parameter logic [7:0]  ID_GEIG      = 8'h47
) (
   input  logic                      CLK_48MHZ,
   input  logic                      RESET,
   input  logic                      TICK_10HZ,
   input  logic [TS_W-1:0]           TIMESTAMP,
   input  logic [NUM_CH-1:0]         GSTREAM,
   output logic [16+TS_W+CNT_W-1:0]  G_DATA_STACK,
   output logic                      G_VALID,
   input  logic                      G_READY,
   output logic                      G_OVERRUN
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
   localparam int TK_W  = $clog2(WINDOW_TICKS + 1);
   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [TK_W-1:0]  TK_LAST  = TK_W'(WINDOW_TICKS - 1);
   localparam logic [6:0]       CH_LAST  = 7'(NUM_CH - 1);

   typedef enum logic {
      IDLE,
      EMIT
   } state_t;

   logic [NUM_CH-1:0] sync_meta;
   logic [NUM_CH-1:0] sync_lvl;
   logic [NUM_CH-1:0] acc_lvl;
   logic [NUM_CH-1:0] acc_rise;
   logic [DB_W-1:0]   db_cnt     [NUM_CH];
   logic [CNT_W-1:0]  live_cnt   [NUM_CH];
   logic [CNT_W-1:0]  shadow_cnt [NUM_CH];
   logic [NUM_CH-1:0] live_sat;
   logic [NUM_CH-1:0] shadow_sat;
   logic [TK_W-1:0]   tick_cnt;
   logic              win_close;
   logic [TS_W-1:0]   ts_latch;
   state_t            state;
   state_t            state_next;
   logic [6:0]        ch_idx;
   logic [6:0]        ch_next;
   logic [SEL_W-1:0]  ch_sel;

   // Two-flop synchroniser on the asynchronous Geiger inputs.
   always_ff @(posedge CLK_48MHZ) begin
      if (RESET) begin
         sync_meta <= '0;
         sync_lvl  <= '0;
      end else begin
         sync_meta <= GSTREAM;
         sync_lvl  <= sync_meta;
      end
   end

   // An event is the cycle on which a rising level gets accepted, i.e. the
   // DEBOUNCE_CYC-th consecutive high sample while the accepted level is low.
   always_comb begin
      acc_rise = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         acc_rise[i] = sync_lvl[i] && !acc_lvl[i] && (db_cnt[i] == DB_LAST);
      end
   end

   // Debounce: count consecutive samples that disagree with the accepted
   // level; any agreeing sample restarts the count.
   always_ff @(posedge CLK_48MHZ) begin
      if (RESET) begin
         acc_lvl <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sync_lvl[i] != acc_lvl[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  acc_lvl[i] <= sync_lvl[i];
                  db_cnt[i]  <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + DB_W'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign win_close = TICK_10HZ && (tick_cnt == TK_LAST);

   always_ff @(posedge CLK_48MHZ) begin
      if (RESET) begin
         tick_cnt <= '0;
      end else if (TICK_10HZ) begin
         tick_cnt <= win_close ? '0 : tick_cnt + TK_W'(1);
      end
   end

   // Live counters. An event on the close cycle belongs to the new window.
   // SAT marks that an event arrived while the counter was already at its
   // maximum, so the reported count is clipped.
   always_ff @(posedge CLK_48MHZ) begin
      if (RESET) begin
         live_sat <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            live_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (win_close) begin
               live_cnt[i] <= acc_rise[i] ? CNT_W'(1) : '0;
               live_sat[i] <= 1'b0;
            end else if (acc_rise[i]) begin
               if (live_cnt[i] == CNT_MAX) begin
                  live_sat[i] <= 1'b1;
               end else begin
                  live_cnt[i] <= live_cnt[i] + CNT_W'(1);
               end
            end
         end
      end
   end

   // Snapshot only when the emitter is free; a close during EMIT discards the
   // new window and raises the sticky overrun flag instead.
   always_ff @(posedge CLK_48MHZ) begin
      if (RESET) begin
         shadow_sat <= '0;
         ts_latch   <= '0;
         G_OVERRUN  <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_cnt[i] <= '0;
         end
      end else if (win_close) begin
         if (state == IDLE) begin
            shadow_sat <= live_sat;
            ts_latch   <= TIMESTAMP;
            for (int i = 0; i < NUM_CH; i++) begin
               shadow_cnt[i] <= live_cnt[i];
            end
         end else begin
            G_OVERRUN <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK_48MHZ) begin
      if (RESET) begin
         state  <= IDLE;
         ch_idx <= '0;
      end else begin
         state  <= state_next;
         ch_idx <= ch_next;
      end
   end

   // Emission sequencing: one word per channel, advancing on each transfer.
   always_comb begin
      state_next = state;
      ch_next    = ch_idx;
      case (state)
         IDLE: begin
            ch_next = '0;
            if (win_close) begin
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (G_READY) begin
               if (ch_idx == CH_LAST) begin
                  state_next = IDLE;
                  ch_next    = '0;
               end else begin
                  ch_next = ch_idx + 7'd1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            ch_next    = '0;
         end
      endcase
   end

   // Word assembly; the bus is forced to zero whenever no word is offered.
   always_comb begin
      G_VALID      = (state == EMIT);
      ch_sel       = ch_idx[SEL_W-1:0];
      G_DATA_STACK = '0;
      if (G_VALID) begin
         G_DATA_STACK = {ID_GEIG, ts_latch, shadow_sat[ch_sel], ch_idx, shadow_cnt[ch_sel]};
      end
   end

endmodule
